// File: rtl/cpu_bus_if_pkg.sv
// Shared constants for the CPU-side memory access initiator.
// Holds FSM state encodings, the SPM address tag, and the bus-level
// READ/WRITE and active-low ENABLE_/DISABLE_ values.
package cpu_bus_if_pkg;

  // Bus FSM states (2-bit encoding, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_STALL  = 2'd3;

  // Transfer direction on rw / spm_rw / bus_rw
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Levels for the active-low strobes, request, grant and ready
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // The SPM is selected by the top TAG_W bits of the word address
  localparam int         TAG_W           = 3;
  localparam logic [2:0] SPM_TAG_DEFAULT = 3'b011;

endpackage

// File: rtl/cpu_bus_if.sv
// CPU-side memory access initiator for one pipeline stage (IF or MEM).
// Ports: stage side (addr/as_/rw/wr_data/rd_data, stall/flush/busy),
//        SPM port (spm_*, 1-cycle read latency) and bus master (bus_*).
// SPM hits are serviced combinationally with no stall; all other addresses
// run a request/grant/ready bus transaction while busy holds the stage.
// Bus-side outputs are registered; busy and the SPM port are combinational.
module cpu_bus_if
  import cpu_bus_if_pkg::*;
#(
  parameter int         ADDR_W     = 30,
  parameter int         DATA_W     = 32,
  parameter int         SPM_ADDR_W = 12,
  parameter logic [2:0] SPM_TAG    = SPM_TAG_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_,
  input  logic                  bus_grnt_,
  output logic                  bus_req_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_wr_data
);

  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d;   // active-low level, as driven
  logic              bus_as_q, bus_as_d;     // active-low level, as driven
  logic              bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              sel_spm_q;

  logic idle;
  logic launch;
  logic spm_hit;

  assign idle    = (state_q == ST_IDLE);
  assign launch  = idle && (as_ == ENABLE_) && !stall && !flush;
  assign spm_hit = (addr[ADDR_W-1 -: TAG_W] == SPM_TAG);

  // SPM port. The strobe follows the stage even while stalled so a read can
  // start early, but a write is only presented in the cycle the access
  // actually launches; otherwise a stalled or flushed write would land in
  // the SPM more than once or not at all.
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_wr_data = wr_data;
  assign spm_as_     = (idle && (as_ == ENABLE_) && spm_hit) ? ENABLE_ : DISABLE_;
  assign spm_rw      = launch ? rw : READ;

  // SPM data arrives one cycle after the strobe; select it only in that cycle
  assign rd_data = sel_spm_q ? spm_rd_data : rd_buf_q;

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

  // Bus master FSM. stall/flush only gate the launch; once requested, a
  // transaction always runs to completion.
  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    busy          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch && !spm_hit) begin
          busy          = 1'b1;
          bus_addr_d    = addr;
          bus_rw_d      = rw;
          bus_wr_data_d = wr_data;
          bus_req_d     = ENABLE_;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        // bus_rdy_ is deliberately ignored here, even alongside a grant
        busy = 1'b1;
        if (bus_grnt_ == ENABLE_) begin
          bus_as_d = ENABLE_;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus_as_d = DISABLE_;              // strobe is a single-cycle pulse
        if (bus_rdy_ == ENABLE_) begin
          if (bus_rw_q == READ) begin
            rd_buf_d = bus_rd_data;
          end
          bus_req_d = DISABLE_;
          state_d   = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_STALL: begin
        // Result is held in rd_buf until the pipeline moves on
        if (!stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bus_req_q     <= DISABLE_;
      bus_as_q      <= DISABLE_;
      bus_rw_q      <= READ;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
      sel_spm_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      sel_spm_q     <= launch && spm_hit;
    end
  end

endmodule

// File: tb/tb_cpu_bus_if.sv
// Directed testbench for cpu_bus_if.
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further unit later, well away from the next edge.
module tb_cpu_bus_if;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [31:0] spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic        bus_grnt_;
  logic        bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;

  int checks = 0;
  int errors = 0;

  cpu_bus_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
    .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = '0; as_ = 1'b1; rw = 1'b1;
    wr_data = '0; spm_rd_data = '0; bus_rd_data = '0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
    next(); next();
    #1;
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL rst_req: got %b want 1", bus_req_); end
    checks++; if (bus_as_ !== 1'b1) begin errors++; $display("FAIL rst_as: got %b want 1", bus_as_); end
    checks++; if (bus_rw !== 1'b1) begin errors++; $display("FAIL rst_rw: got %b want 1", bus_rw); end
    checks++; if (bus_addr !== 30'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus_addr); end
    checks++; if (bus_wr_data !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus_wr_data); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b0;
    next();
  endtask

  task automatic test_spm_read();
    addr = 30'h18000010; as_ = 1'b0; rw = 1'b1;
    #1;
    checks++; if (spm_as_ !== 1'b0) begin errors++; $display("FAIL spm_rd_as: got %b want 0", spm_as_); end
    checks++; if (spm_addr !== 12'h010) begin errors++; $display("FAIL spm_rd_addr: got %h want 010", spm_addr); end
    checks++; if (spm_rw !== 1'b1) begin errors++; $display("FAIL spm_rd_rw: got %b want 1", spm_rw); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spm_rd_busy0: got %b want 0", busy); end
    next();
    as_ = 1'b1; spm_rd_data = 32'h12345678;
    #1;
    checks++; if (rd_data !== 32'h12345678) begin errors++; $display("FAIL spm_rd_data: got %h want 12345678", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spm_rd_busy1: got %b want 0", busy); end
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL spm_rd_no_req: got %b want 1", bus_req_); end
    next();
    #1;
    // SPM data is only selected in the cycle after the strobe
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL spm_rd_release: got %h want 0", rd_data); end
  endtask

  task automatic test_spm_write_stall();
    addr = 30'h18000020; as_ = 1'b0; rw = 1'b0; wr_data = 32'hA5A5A5A5; stall = 1'b1;
    #1;
    checks++; if (spm_as_ !== 1'b0) begin errors++; $display("FAIL spm_wr_as_stall: got %b want 0", spm_as_); end
    checks++; if (spm_rw !== 1'b1) begin errors++; $display("FAIL spm_wr_rw_stall: got %b want 1", spm_rw); end
    next();
    stall = 1'b0;
    #1;
    checks++; if (spm_rw !== 1'b0) begin errors++; $display("FAIL spm_wr_rw_go: got %b want 0", spm_rw); end
    checks++; if (spm_wr_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL spm_wr_data: got %h want a5a5a5a5", spm_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spm_wr_busy: got %b want 0", busy); end
    next();
    as_ = 1'b1; rw = 1'b1;
    #1;
    checks++; if (spm_as_ !== 1'b1) begin errors++; $display("FAIL spm_wr_as_end: got %b want 1", spm_as_); end
    checks++; if (spm_rw !== 1'b1) begin errors++; $display("FAIL spm_wr_rw_end: got %b want 1", spm_rw); end
    next();
  endtask

  task automatic test_bus_read();
    int req_low;
    int as_low;
    addr = 30'h00000100; as_ = 1'b0; rw = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brd_busy_launch: got %b want 1", busy); end
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL brd_req_pre: got %b want 1", bus_req_); end
    next();
    as_ = 1'b1; req_low = 0; as_low = 0;
    // grant in cycle 3 (rdy also low there and in cycle 1: must be ignored), rdy in cycle 5
    for (int c = 0; c < 6; c++) begin
      bus_grnt_   = (c == 3) ? 1'b0 : 1'b1;
      bus_rdy_    = (c == 1 || c == 3 || c == 5) ? 1'b0 : 1'b1;
      bus_rd_data = (c == 5) ? 32'hDEADBEEF : 32'hBAD0BAD0;
      #1;
      if (bus_req_ == 1'b0) req_low++;
      if (bus_as_ == 1'b0) as_low++;
      checks++; if (busy !== (c != 5)) begin errors++; $display("FAIL brd_busy_c%0d: got %b want %b", c, busy, c != 5); end
      if (c == 0) begin
        checks++; if (bus_addr !== 30'h100) begin errors++; $display("FAIL brd_addr: got %h want 100", bus_addr); end
        checks++; if (bus_rw !== 1'b1) begin errors++; $display("FAIL brd_rw: got %b want 1", bus_rw); end
      end
      next();
    end
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    #1;
    checks++; if (req_low !== 6) begin errors++; $display("FAIL brd_req_cycles: got %0d want 6", req_low); end
    checks++; if (as_low !== 1) begin errors++; $display("FAIL brd_as_cycles: got %0d want 1", as_low); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL brd_data: got %h want deadbeef", rd_data); end
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL brd_req_post: got %b want 1", bus_req_); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brd_busy_post: got %b want 0", busy); end
  endtask

  task automatic test_bus_write_stall();
    addr = 30'h00000200; as_ = 1'b0; rw = 1'b0; wr_data = 32'hCAFEF00D;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bwr_busy_launch: got %b want 1", busy); end
    next();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    #1;
    checks++; if (bus_rw !== 1'b0) begin errors++; $display("FAIL bwr_rw: got %b want 0", bus_rw); end
    checks++; if (bus_wr_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bwr_wdata: got %h want cafef00d", bus_wr_data); end
    checks++; if (bus_addr !== 30'h200) begin errors++; $display("FAIL bwr_addr: got %h want 200", bus_addr); end
    next();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; stall = 1'b1; bus_rd_data = 32'h11111111;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bwr_busy_rdy: got %b want 0", busy); end
    next();
    bus_rdy_ = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bwr_busy_stall: got %b want 0", busy); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bwr_rdbuf_kept: got %h want deadbeef", rd_data); end
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL bwr_req_rel: got %b want 1", bus_req_); end
    next();
    // Still in STALL: a bus request this cycle must not launch
    stall = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 30'h00000280;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bwr_stall_nolaunch: got %b want 0", busy); end
    next();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bwr_idle_launch: got %b want 1", busy); end
    next();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    #1;
    checks++; if (bus_addr !== 30'h280) begin errors++; $display("FAIL bwr_next_addr: got %h want 280", bus_addr); end
    next();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h55AA55AA;
    next();
    bus_rdy_ = 1'b1;
    #1;
    checks++; if (rd_data !== 32'h55AA55AA) begin errors++; $display("FAIL bwr_next_data: got %h want 55aa55aa", rd_data); end
  endtask

  task automatic test_back_to_back();
    // Launch in the IDLE cycle straight after ACCESS
    addr = 30'h000002C0; as_ = 1'b0; rw = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    next();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    #1;
    checks++; if (bus_req_ !== 1'b0) begin errors++; $display("FAIL b2b_req: got %b want 0", bus_req_); end
    checks++; if (bus_addr !== 30'h2C0) begin errors++; $display("FAIL b2b_addr: got %h want 2c0", bus_addr); end
    next();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h00000077;
    next();
    bus_rdy_ = 1'b1;
    #1;
    checks++; if (rd_data !== 32'h00000077) begin errors++; $display("FAIL b2b_data: got %h want 00000077", rd_data); end
  endtask

  task automatic test_flush();
    addr = 30'h00000300; as_ = 1'b0; rw = 1'b1; flush = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy_blocked: got %b want 0", busy); end
    next();
    #1;
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL fl_no_req: got %b want 1", bus_req_); end
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_launch: got %b want 1", busy); end
    next();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    next();
    bus_grnt_ = 1'b1; flush = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_access_busy: got %b want 1", busy); end
    checks++; if (bus_req_ !== 1'b0) begin errors++; $display("FAIL fl_access_req: got %b want 0", bus_req_); end
    next();
    bus_rdy_ = 1'b0; bus_rd_data = 32'h0F0F0F0F;
    next();
    bus_rdy_ = 1'b1; flush = 1'b0;
    #1;
    checks++; if (rd_data !== 32'h0F0F0F0F) begin errors++; $display("FAIL fl_data: got %h want 0f0f0f0f", rd_data); end
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL fl_req_rel: got %b want 1", bus_req_); end
  endtask

  task automatic test_reset_mid();
    addr = 30'h00000400; as_ = 1'b0; rw = 1'b1;
    next();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    next();
    bus_grnt_ = 1'b1;
    #1;
    checks++; if (bus_as_ !== 1'b0) begin errors++; $display("FAIL rm_as_pre: got %b want 0", bus_as_); end
    reset = 1'b1;
    #1;
    checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL rm_req: got %b want 1", bus_req_); end
    checks++; if (bus_as_ !== 1'b1) begin errors++; $display("FAIL rm_as: got %b want 1", bus_as_); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rm_rd_data: got %h want 0", rd_data); end
    checks++; if (bus_addr !== 30'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", bus_addr); end
    next();
    reset = 1'b0;
    next();
  endtask

  initial begin
    test_reset();
    test_spm_read();
    test_spm_write_stall();
    test_bus_read();
    test_bus_write_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
